current_sense_sequencer: RTL and testbench

//  Periodically triggers a 16-bit SPI read of the TLI4970 current sensor via the existing spi_master.

---
 rtl/current_sense_sequencer.sv | 138 +++++++++++++
 tb/tb_current_sense_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/current_sense_sequencer.sv
// Periodic TLI4970 read sequencer: triggers spi_master, validates frames,
// publishes signed current samples and keeps timeout/error accounting.
`timescale 1ns/1ps
module current_sense_sequencer #(
    parameter int PERIOD_CYCLES  = 64000,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int OFFSET         = 4096
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear_errors,
    output logic        spi_wren,
    input  logic        spi_do_valid,
    input  logic [15:0] spi_do,
    output logic [12:0] current,
    output logic        current_valid,
    output logic        overcurrent,
    output logic        parity_err,
    output logic        timeout_err,
    output logic        overrun_err,
    output logic [7:0]  error_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        CHECK,
        WAIT_PERIOD
    } state_t;

    localparam logic [31:0] P_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] T_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [12:0] OFS    = 13'(OFFSET);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] period_cnt;
    logic [31:0] timeout_cnt;
    logic [15:0] raw;

    logic tick;
    logic t_expired;
    logic timeout_hit;
    logic parity_bad;
    logic status_frame;
    logic accept;
    logic overrun_hit;
    logic err_inc;

    // Counter comparisons; tick is meaningless while parked in IDLE
    assign tick      = (state != IDLE) && (period_cnt == P_LAST);
    assign t_expired = (timeout_cnt == T_LAST);

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; do_valid beats a coincident timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:        if (enable) state_nxt = REQUEST;
            REQUEST:     state_nxt = WAIT_DATA;
            WAIT_DATA: begin
                if (spi_do_valid)   state_nxt = CHECK;
                else if (t_expired) state_nxt = WAIT_PERIOD;
            end
            CHECK:       state_nxt = WAIT_PERIOD;
            WAIT_PERIOD: if (tick) state_nxt = enable ? REQUEST : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Output decode: strobe and per-cycle error/accept events
    always_comb begin
        spi_wren     = (state == REQUEST);
        timeout_hit  = (state == WAIT_DATA) && !spi_do_valid && t_expired;
        parity_bad   = (state == CHECK) && (^raw);
        status_frame = (state == CHECK) && !(^raw) && raw[15];
        accept       = (state == CHECK) && !(^raw) && !raw[15];
        overrun_hit  = tick && ((state == WAIT_DATA) || (state == CHECK));
        err_inc      = timeout_hit | parity_bad | status_frame;
    end

    // Period and timeout counters; both read 0 during the REQUEST cycle
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state_nxt == REQUEST) period_cnt <= '0;
            else if (state != IDLE)   period_cnt <= tick ? '0 : period_cnt + 32'd1;
            if (state_nxt == REQUEST) timeout_cnt <= '0;
            else if (state == REQUEST || state == WAIT_DATA)
                timeout_cnt <= timeout_cnt + 32'd1;
        end
    end

    // Frame capture and published sample
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            raw           <= '0;
            current       <= '0;
            overcurrent   <= 1'b0;
            current_valid <= 1'b0;
        end else begin
            if (state == WAIT_DATA && spi_do_valid) raw <= spi_do;
            current_valid <= accept;
            if (accept) begin
                current     <= raw[12:0] - OFS;
                overcurrent <= raw[13];
            end
        end
    end

    // Sticky flags and saturating error count; a new error beats clear
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            error_count <= '0;
        end else begin
            parity_err  <= parity_bad  | (parity_err  & ~clear_errors);
            timeout_err <= timeout_hit | (timeout_err & ~clear_errors);
            overrun_err <= overrun_hit | (overrun_err & ~clear_errors);
            if (clear_errors)
                error_count <= err_inc ? 8'd1 : 8'd0;
            else if (err_inc && error_count != 8'hFF)
                error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_current_sense_sequencer.sv
// Directed + randomized bench for current_sense_sequencer with a
// frame-level reference model and wren timing derived from the period.
`timescale 1ns/1ps
module tb_current_sense_sequencer;

    localparam int P    = 128;
    localparam int T    = 48;
    localparam int OFFS = 4096;
    localparam int P2   = 100;
    localparam int T2   = 300;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        enable = 0;
    logic        clear_errors = 0;
    logic        spi_wren;
    logic        spi_do_valid = 0;
    logic [15:0] spi_do = 0;
    logic [12:0] current;
    logic        current_valid;
    logic        overcurrent;
    logic        parity_err;
    logic        timeout_err;
    logic        overrun_err;
    logic [7:0]  error_count;

    logic        en2 = 0;
    logic        clr2 = 0;
    logic        wren2;
    logic        dv2 = 0;
    logic [15:0] do2 = 0;
    logic [12:0] cur2;
    logic        cv2;
    logic        oc2;
    logic        par2;
    logic        to2;
    logic        ov2;
    logic [7:0]  ec2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [12:0] exp_cur;
    logic        exp_oc;
    logic        exp_par;
    logic        exp_to;
    int          exp_cnt;

    current_sense_sequencer #(
        .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .OFFSET(OFFS)
    ) dut (
        .CLK(clk), .reset_n(rst_n), .enable(enable),
        .clear_errors(clear_errors), .spi_wren(spi_wren),
        .spi_do_valid(spi_do_valid), .spi_do(spi_do),
        .current(current), .current_valid(current_valid),
        .overcurrent(overcurrent), .parity_err(parity_err),
        .timeout_err(timeout_err), .overrun_err(overrun_err),
        .error_count(error_count)
    );

    current_sense_sequencer #(
        .PERIOD_CYCLES(P2), .TIMEOUT_CYCLES(T2), .OFFSET(OFFS)
    ) dut2 (
        .CLK(clk), .reset_n(rst_n), .enable(en2),
        .clear_errors(clr2), .spi_wren(wren2),
        .spi_do_valid(dv2), .spi_do(do2),
        .current(cur2), .current_valid(cv2),
        .overcurrent(oc2), .parity_err(par2),
        .timeout_err(to2), .overrun_err(ov2),
        .error_count(ec2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_cur = '0;
        exp_oc  = 1'b0;
        exp_par = 1'b0;
        exp_to  = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic bump();
        if (exp_cnt < 255) exp_cnt++;
    endtask

    // Frame rules: odd bit count -> parity reject, bit15 -> status reject
    task automatic model(input logic [15:0] f, output logic ok);
        ok = 1'b0;
        if ($countones(f) % 2 == 1) begin
            exp_par = 1'b1;
            bump();
        end else if (f[15]) begin
            bump();
        end else begin
            exp_cur = 13'((int'(f[12:0]) - OFFS) & 8191);
            exp_oc  = f[13];
            ok      = 1'b1;
        end
    endtask

    task automatic txn(input logic [15:0] f, input int d);
        logic ok;
        step(d);
        spi_do = f;
        spi_do_valid = 1'b1;
        step();
        spi_do_valid = 1'b0;
        chk("cv_early", current_valid, 0);
        step();
        model(f, ok);
        chk("cv", current_valid, ok);
        chk("current", current, exp_cur);
        chk("ocd", overcurrent, exp_oc);
        chk("parity_err", parity_err, exp_par);
        chk("timeout_err", timeout_err, exp_to);
        chk("err_cnt", error_count, exp_cnt);
        step();
        chk("cv_drop", current_valid, 0);
    endtask

    task automatic wait_wren(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (spi_wren === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int w;
        int t;
        logic seen;
        logic [15:0] f;
        logic [15:0] dir [5];
        dir[0] = 16'h5000;
        dir[1] = 16'h7001;
        dir[2] = 16'h0FFF;
        dir[3] = 16'h5001;
        dir[4] = 16'hC000;
        model_reset();

        step(2);
        chk("rst_wren", spi_wren, 0);
        chk("rst_current", current, 0);
        chk("rst_cv", current_valid, 0);
        chk("rst_flags", {parity_err, timeout_err, overrun_err, overcurrent}, 0);
        chk("rst_cnt", error_count, 0);
        rst_n = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= spi_wren;
        end
        chk("idle_no_wren", seen, 0);

        enable = 1'b1;
        step();
        chk("first_wren", spi_wren, 1);
        w = cyc;

        for (int i = 0; i < 13; i++) begin
            if (i < 5) txn(dir[i], (i == 0) ? 40 : 10 + i);
            else       txn(16'($urandom), int'($urandom_range(1, 40)));
            wait_wren(P + 4, t);
            chk("period", t - w, P);
            w = t;
        end

        txn(16'h5000, 7);
        f = (exp_cur == 13'd0) ? 16'h7001 : 16'h5000;
        spi_do = f;
        spi_do_valid = 1'b1;
        step();
        spi_do_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= current_valid;
            step();
        end
        chk("stray_cv", seen, 0);
        chk("stray_current", current, exp_cur);
        wait_wren(P + 4, t);
        chk("period_stray", t - w, P);
        w = t;

        for (int i = 0; i < T + 5; i++) begin
            step();
            if (timeout_err === 1'b1) break;
        end
        chk("timeout_at", cyc - w, T);
        exp_to = 1'b1;
        bump();
        chk("timeout_cnt", error_count, exp_cnt);
        chk("timeout_cur", current, exp_cur);
        wait_wren(P + 4, t);
        chk("period_to", t - w, P);
        w = t;

        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        model_reset();
        exp_cur = current === exp_cur ? exp_cur : exp_cur;
        chk("clear_flags", {parity_err, timeout_err, overrun_err}, 0);
        chk("clear_cnt", error_count, 0);
        exp_cur = 13'h0;
        txn(16'h7001, 5);
        wait_wren(P + 4, t);
        chk("period_clr", t - w, P);
        w = t;

        for (int i = 0; i < 260; i++) begin
            txn(16'h5001, 1);
            wait_wren(P + 4, t);
            chk("period_sat", t - w, P);
            w = t;
        end
        chk("sat_cnt", error_count, 255);

        enable = 1'b0;
        txn(16'h0FFF, 9);
        seen = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            seen |= spi_wren;
        end
        chk("disable_no_wren", seen, 0);

        enable = 1'b1;
        step();
        chk("restart_wren", spi_wren, 1);
        step(5);
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_wren", spi_wren, 0);
        chk("arst_current", current, 0);
        chk("arst_flags", {parity_err, timeout_err, overrun_err, overcurrent}, 0);
        chk("arst_cnt", error_count, 0);
        model_reset();
        step(3);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= spi_wren;
        end
        chk("post_rst_no_wren", seen, 0);
        enable = 1'b1;
        step();
        chk("post_rst_wren", spi_wren, 1);
        w = cyc;

        txn(16'h5001, 3);
        wait_wren(P + 4, t);
        chk("period_j", t - w, P);
        w = t;
        step(T - 1);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        chk("clr_to_flag", timeout_err, 1);
        chk("clr_to_cnt", error_count, 1);
        chk("clr_to_par", parity_err, 0);
        enable = 1'b0;

        en2 = 1'b1;
        step();
        chk("ov_wren", wren2, 1);
        w = cyc;
        step(P2 - 1);
        chk("ov_before", ov2, 0);
        step();
        chk("ov_set", ov2, 1);
        step(50);
        do2 = 16'h7001;
        dv2 = 1'b1;
        step();
        dv2 = 1'b0;
        step();
        chk("ov_cv", cv2, 1);
        chk("ov_current", cur2, 1);
        chk("ov_ocd", oc2, 1);
        t = -1;
        for (int i = 0; i < P2 + 4; i++) begin
            step();
            if (wren2 === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk("ov_next_wren", t - w, 2 * P2);
        en2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
